// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is registered.
module param_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          clr_err,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A fresh rejection in the same cycle as clr_err keeps the flag set.
      if (wr_en && !wr_acc) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd_en && !rd_acc) underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: queue-based reference model, directed scenarios and random traffic.
module tb_param_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int OBS_W = 5 + 6 + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  param_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents as a queue plus sticky flags and registered output.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  function automatic logic [OBS_W-1:0] model_obs();
    int n = q.size();
    logic [DW-1:0] d;
`ifdef FIFO_FWFT_EN
    d = (n != 0) ? q[0] : '0;
`else
    d = m_dout;
`endif
    return {5'(n), n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2, m_ovf, m_unf, d};
  endfunction

  wire [OBS_W-1:0] dut_obs = {count, full, empty, almost_full, almost_empty,
                              overflow, underflow, data_out};

  function automatic void model_reset();
    q.delete();
    m_ovf  = 0;
    m_unf  = 0;
    m_dout = '0;
  endfunction

  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    bit rd_ok, wr_ok;
    logic [DW-1:0] head;
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d; clr_err = c;
    rd_ok = r && (q.size() != 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    m_ovf = (w && !wr_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (r && !rd_ok) ? 1'b1 : (c ? 1'b0 : m_unf);
    if (rd_ok) begin
      head = q.pop_front();
      m_dout = head;
    end
    if (wr_ok) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (dut_obs !== model_obs()) begin
      miscompares++;
      $display("FAIL reset_obs: got %h expected %h", dut_obs, model_obs());
    end
    vectors++;
    if ({empty, full, almost_empty, almost_full, count, data_out} !== {4'b1010, 5'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_flags: got e=%b f=%b ae=%b af=%b cnt=%0d dout=%h",
               empty, full, almost_empty, almost_full, count, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1, 0, DW'(i), 0);
      vectors++;
      if (dut_obs !== model_obs()) begin
        miscompares++;
        $display("FAIL fill_obs[%0d]: got %h expected %h", i, dut_obs, model_obs());
      end
      vectors++;
      if (almost_full !== (i >= DEPTH - 2)) begin
        miscompares++;
        $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, i >= DEPTH - 2);
      end
    end
    vectors++;
    if ({full, count} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=16", full, count);
    end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 8'hAA, 0);
    vectors++;
    if ({overflow, count} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("FAIL ovf_set: got ovf=%b count=%0d expected ovf=1 count=16", overflow, count);
    end
    cycle(0, 0, '0, 1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
      vectors++;
      if (data_out !== DW'(i)) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d]: got %h expected %h", i, data_out, DW'(i));
      end
      cycle(0, 1, '0, 0);
`else
      cycle(0, 1, '0, 0);
      vectors++;
      if (data_out !== DW'(i)) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d]: got %h expected %h", i, data_out, DW'(i));
      end
`endif
    end
    vectors++;
    if (dut_obs !== model_obs()) begin
      miscompares++;
      $display("FAIL ovf_end: got %h expected %h", dut_obs, model_obs());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(0, 1, '0, 0);
    vectors++;
    if ({underflow, count, data_out} !== {1'b1, 5'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL unf_set: got unf=%b count=%0d dout=%h expected 1/0/00", underflow, count, data_out);
    end
    // Clear with a simultaneous new underflow: the new error must win.
    cycle(0, 1, '0, 1);
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL unf_clr_race: got %b expected 1", underflow);
    end
    cycle(0, 0, '0, 1);
    vectors++;
    if (dut_obs !== model_obs()) begin
      miscompares++;
      $display("FAIL unf_clear: got %h expected %h", dut_obs, model_obs());
    end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, DW'(i), 0);
    cycle(1, 1, 8'h55, 0);
    vectors++;
    if ({count, overflow} !== {5'd16, 1'b0}) begin
      miscompares++;
      $display("FAIL full_rw: got count=%0d ovf=%b expected 16/0", count, overflow);
    end
    // Entry 0x01 left on the simultaneous cycle; expect 0x02..0x10 then 0x55.
    for (int i = 2; i <= DEPTH + 1; i++) begin
      logic [DW-1:0] exp_d;
      exp_d = (i == DEPTH + 1) ? 8'h55 : DW'(i);
`ifdef FIFO_FWFT_EN
      vectors++;
      if (data_out !== exp_d) begin
        miscompares++;
        $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, data_out, exp_d);
      end
      cycle(0, 1, '0, 0);
`else
      cycle(0, 1, '0, 0);
      vectors++;
      if (data_out !== exp_d) begin
        miscompares++;
        $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, data_out, exp_d);
      end
`endif
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    cycle(1, 1, 8'h3C, 0);
    vectors++;
    if ({count, underflow, overflow} !== {5'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL empty_rw: got count=%0d unf=%b ovf=%b expected 1/1/0", count, underflow, overflow);
    end
    cycle(0, 1, '0, 1);
    vectors++;
    if (dut_obs !== model_obs()) begin
      miscompares++;
      $display("FAIL empty_rw_pop: got %h expected %h", dut_obs, model_obs());
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bit r;
      r = (i >= 6) && ($urandom_range(0, 2) != 0);
      cycle(1, r, DW'($urandom), 0);
      vectors++;
      if (dut_obs !== model_obs()) begin
        miscompares++;
        $display("FAIL wrap_obs[%0d]: got %h expected %h", i, dut_obs, model_obs());
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_rst: got count=%0d empty=%b expected 0/1", count, empty);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 8'h77, 0);
`ifdef FIFO_FWFT_EN
    vectors++;
    if (data_out !== 8'h77) begin
      miscompares++;
      $display("FAIL wrap_post: got %h expected 77", data_out);
    end
`else
    cycle(0, 1, '0, 0);
    vectors++;
    if (data_out !== 8'h77) begin
      miscompares++;
      $display("FAIL wrap_post: got %h expected 77", data_out);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int wp;
      bit w, r, c;
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      w  = $urandom_range(0, 99) < wp;
      r  = $urandom_range(0, 99) < (100 - wp);
      c  = $urandom_range(0, 15) == 0;
      cycle(w, r, DW'($urandom), c);
      vectors++;
      if (dut_obs !== model_obs()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_obs, model_obs());
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_full_rw();
    test_empty_rw();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
